// File: rtl/dmem_cache_ctrl_if.sv
// dmem_cache_ctrl_if
// Core-side request/response and memory-side load/store signals of the
// L1 data cache controller, bundled so the controller and its environment
// share one definition.
//   master : the cache controller (serves the core, drives the memory port)
//   slave  : the environment (core + data memory)
interface dmem_cache_ctrl_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 32
);
    logic              core_req;
    logic              core_we;
    logic [ADDR_W-1:0] core_addr;
    logic [DATA_W-1:0] core_wdata;
    logic              core_done;
    logic [DATA_W-1:0] core_rdata;

    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_load_control;
    logic              mem_store_control;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        input  core_req,
        input  core_we,
        input  core_addr,
        input  core_wdata,
        output core_done,
        output core_rdata,
        output mem_address,
        output mem_wdata,
        output mem_load_control,
        output mem_store_control,
        input  mem_rdata
    );

    modport slave (
        output core_req,
        output core_we,
        output core_addr,
        output core_wdata,
        input  core_done,
        input  core_rdata,
        input  mem_address,
        input  mem_wdata,
        input  mem_load_control,
        input  mem_store_control,
        output mem_rdata
    );
endinterface

// File: rtl/dmem_cache_ctrl.sv
// dmem_cache_ctrl
// Direct-mapped, write-through, no-write-allocate L1 data cache controller,
// one word per line. Read hits are answered from the cache; read misses
// and every store go out on the memory port for exactly one cycle.
//
// Optional build macro DMEM_CACHE_SNOOP_INV_EN adds snoop_valid/snoop_addr,
// fed from the other core's store port; a matching valid line is dropped.
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | waiting for core_req; request is latched at the edge
// FILL    | read miss: memory read this cycle, line refilled at edge
// WRITE   | store: memory write this cycle, line updated on a hit
// RESP    | core_done pulse for one cycle
module dmem_cache_ctrl #(
    parameter int ADDR_W  = 4,
    parameter int DATA_W  = 32,
    parameter int INDEX_W = 2
) (
    input  logic              clk,
    input  logic              reset,
`ifdef DMEM_CACHE_SNOOP_INV_EN
    input  logic              snoop_valid,
    input  logic [ADDR_W-1:0] snoop_addr,
`endif
    dmem_cache_ctrl_if.master io_bus
);

    localparam int NUM_LINES = 1 << INDEX_W;
    localparam int TAG_W     = ADDR_W - INDEX_W;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_WRITE = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata;

    logic              r_valid [NUM_LINES];
    logic [TAG_W-1:0]  r_tag   [NUM_LINES];
    logic [DATA_W-1:0] r_data  [NUM_LINES];

    logic [INDEX_W-1:0] w_req_idx;
    logic [TAG_W-1:0]   w_req_tag;
    logic               w_req_hit;
    logic [INDEX_W-1:0] w_q_idx;
    logic [TAG_W-1:0]   w_q_tag;
    logic               w_q_hit;

    logic               w_accept;
    logic               w_snp_kill;
    logic [INDEX_W-1:0] w_snp_idx;

    logic               w_core_done;
    logic [ADDR_W-1:0]  w_mem_address;
    logic [DATA_W-1:0]  w_mem_wdata;
    logic               w_mem_load;
    logic               w_mem_store;

    // Lookup for the incoming request (IDLE) and for the latched one (FILL/WRITE).
    assign w_req_idx = io_bus.core_addr[INDEX_W-1:0];
    assign w_req_tag = io_bus.core_addr[ADDR_W-1:INDEX_W];
    assign w_req_hit = r_valid[w_req_idx] && (r_tag[w_req_idx] == w_req_tag);

    assign w_q_idx   = r_addr[INDEX_W-1:0];
    assign w_q_tag   = r_addr[ADDR_W-1:INDEX_W];
    assign w_q_hit   = r_valid[w_q_idx] && (r_tag[w_q_idx] == w_q_tag);

    assign w_accept  = (r_state == ST_IDLE) && io_bus.core_req;

`ifdef DMEM_CACHE_SNOOP_INV_EN
    logic [TAG_W-1:0] w_snp_tag;
    logic             w_snp_match_line;
    logic             w_snp_match_fill;

    assign w_snp_idx = snoop_addr[INDEX_W-1:0];
    assign w_snp_tag = snoop_addr[ADDR_W-1:INDEX_W];

    // A line being refilled this cycle is not yet valid, so compare the
    // snoop against the fill address too; otherwise the refill would
    // resurrect data the other core has just overwritten.
    assign w_snp_match_line = r_valid[w_snp_idx] && (r_tag[w_snp_idx] == w_snp_tag);
    assign w_snp_match_fill = (r_state == ST_FILL) && (snoop_addr == r_addr);
    assign w_snp_kill       = snoop_valid && (w_snp_match_line || w_snp_match_fill);
`else
    assign w_snp_idx  = '0;
    assign w_snp_kill = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode and memory/core strobes; memory port is idle-zero.
    always_comb begin
        w_state_nxt   = r_state;
        w_core_done   = 1'b0;
        w_mem_address = '0;
        w_mem_wdata   = '0;
        w_mem_load    = 1'b0;
        w_mem_store   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (io_bus.core_req) begin
                    if (io_bus.core_we) begin
                        w_state_nxt = ST_WRITE;
                    end else if (w_req_hit) begin
                        w_state_nxt = ST_RESP;
                    end else begin
                        w_state_nxt = ST_FILL;
                    end
                end
            end
            ST_FILL: begin
                w_mem_load    = 1'b1;
                w_mem_address = r_addr;
                w_state_nxt   = ST_RESP;
            end
            ST_WRITE: begin
                w_mem_store   = 1'b1;
                w_mem_address = r_addr;
                w_mem_wdata   = r_wdata;
                w_state_nxt   = ST_RESP;
            end
            ST_RESP: begin
                w_core_done   = 1'b1;
                w_state_nxt   = ST_IDLE;
            end
            default: begin
                w_state_nxt   = ST_IDLE;
            end
        endcase
    end

    // Request capture and load-result register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
        end else begin
            if (w_accept) begin
                r_addr  <= io_bus.core_addr;
                r_wdata <= io_bus.core_wdata;
                if (!io_bus.core_we && w_req_hit) begin
                    r_rdata <= r_data[w_req_idx];
                end
            end
            if (r_state == ST_FILL) begin
                r_rdata <= io_bus.mem_rdata;
            end
        end
    end

    // Valid bits: set on refill, cleared by a snoop; the snoop is applied last
    // so it wins when both hit the same line in one cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_LINES; i++) begin
                r_valid[i] <= 1'b0;
            end
        end else begin
            if (r_state == ST_FILL) begin
                r_valid[w_q_idx] <= 1'b1;
            end
            if (w_snp_kill) begin
                r_valid[w_snp_idx] <= 1'b0;
            end
        end
    end

    // Tag/data arrays: refill on a miss, write-through update only on a store hit.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (r_state == ST_FILL) begin
                r_tag[w_q_idx]  <= w_q_tag;
                r_data[w_q_idx] <= io_bus.mem_rdata;
            end else if ((r_state == ST_WRITE) && w_q_hit) begin
                r_data[w_q_idx] <= r_wdata;
            end
        end
    end

    assign io_bus.core_done         = w_core_done;
    assign io_bus.core_rdata        = r_rdata;
    assign io_bus.mem_address       = w_mem_address;
    assign io_bus.mem_wdata         = w_mem_wdata;
    assign io_bus.mem_load_control  = w_mem_load;
    assign io_bus.mem_store_control = w_mem_store;

endmodule

// File: tb/tb_dmem_cache_ctrl.sv
// tb_dmem_cache_ctrl
// Drives directed and random load/store traffic into dmem_cache_ctrl,
// emulates the asynchronous data memory, and compares every cycle of each
// transaction against a reference model that tracks which word address each
// cache line holds plus the expected memory contents.
// Build with DMEM_CACHE_SNOOP_INV_EN defined to also exercise snoop invalidation.
module tb_dmem_cache_ctrl;

    localparam int ADDR_W  = 4;
    localparam int DATA_W  = 32;
    localparam int INDEX_W = 2;
    localparam int DEPTH   = 1 << ADDR_W;
    localparam int LINES   = 1 << INDEX_W;

    logic clk = 1'b0;
    logic reset;

    dmem_cache_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

`ifdef DMEM_CACHE_SNOOP_INV_EN
    logic              snoop_valid;
    logic [ADDR_W-1:0] snoop_addr;
`endif

    dmem_cache_ctrl #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .INDEX_W (INDEX_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
`ifdef DMEM_CACHE_SNOOP_INV_EN
        .snoop_valid (snoop_valid),
        .snoop_addr  (snoop_addr),
`endif
        .io_bus      (bus)
    );

    always #5 clk = ~clk;

    // Emulated data memory: combinational read, stores committed by the
    // main sequence when it sees mem_store_control before the edge.
    logic [DATA_W-1:0] tb_mem [DEPTH];
    assign bus.mem_rdata = tb_mem[bus.mem_address];

    // Reference model.
    logic [DATA_W-1:0] ref_mem [DEPTH];
    int                line_addr [LINES];
    logic [DATA_W-1:0] last_rdata;

    int n_vec;
    int n_err;
    bit after_done;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got no summary want summary");
        $fatal(1, "watchdog");
    end

    task automatic model_clear();
        for (int i = 0; i < LINES; i++) line_addr[i] = -1;
        last_rdata = '0;
    endtask

    task automatic snoop_model(input logic [ADDR_W-1:0] a);
        int idx;
        idx = int'(a[INDEX_W-1:0]);
        if (line_addr[idx] == int'(a)) line_addr[idx] = -1;
    endtask

    // One core transaction; returns at the negedge of the core_done cycle.
    task automatic run_txn(input bit we, input logic [ADDR_W-1:0] addr,
                           input logic [DATA_W-1:0] wdata, input int gap,
                           input bit snp_fill);
        int                idx;
        bit                hit;
        int                lat;
        bit                done_seen;
        bit                exp_ld;
        bit                exp_st;
        logic [ADDR_W-1:0] exp_a;
        logic [DATA_W-1:0] exp_wd;
        logic [DATA_W-1:0] exp_rd;

        if (gap > 0) begin
            bus.core_req = 1'b0;
            for (int g = 0; g < gap; g++) begin
                @(negedge clk);
                after_done = 1'b0;
                n_vec++;
                if ({bus.core_done, bus.mem_load_control, bus.mem_store_control} !== 3'b000) begin
                    $display("FAIL idle_quiet: got done/ld/st=%b want 000",
                             {bus.core_done, bus.mem_load_control, bus.mem_store_control});
                    n_err++;
                end
            end
        end

        bus.core_req   = 1'b1;
        bus.core_we    = we;
        bus.core_addr  = addr;
        bus.core_wdata = wdata;
        if (after_done) @(negedge clk);

        idx    = int'(addr[INDEX_W-1:0]);
        hit    = !we && (line_addr[idx] == int'(addr));
        lat    = hit ? 1 : 2;
        exp_rd = we ? last_rdata : ref_mem[addr];

        @(posedge clk);
        done_seen = 1'b0;
        for (int k = 1; k <= 3 && !done_seen; k++) begin
            @(negedge clk);
            exp_ld = (k == 1) && !we && !hit;
            exp_st = (k == 1) && we;
            exp_a  = (exp_ld || exp_st) ? addr : '0;
            exp_wd = exp_st ? wdata : '0;

            n_vec++;
            if ({bus.mem_load_control, bus.mem_store_control} !== {exp_ld, exp_st}) begin
                $display("FAIL mem_ctrl: addr=%h we=%0d cyc=%0d got ld/st=%b%b want %b%b",
                         addr, we, k, bus.mem_load_control, bus.mem_store_control, exp_ld, exp_st);
                n_err++;
            end
            n_vec++;
            if (bus.mem_address !== exp_a) begin
                $display("FAIL mem_address: cyc=%0d got %h want %h", k, bus.mem_address, exp_a);
                n_err++;
            end
            n_vec++;
            if (bus.mem_wdata !== exp_wd) begin
                $display("FAIL mem_wdata: cyc=%0d got %h want %h", k, bus.mem_wdata, exp_wd);
                n_err++;
            end
            n_vec++;
            if (bus.core_done !== (k == lat)) begin
                $display("FAIL done_timing: addr=%h we=%0d cyc=%0d got %b want %b",
                         addr, we, k, bus.core_done, (k == lat));
                n_err++;
            end
            if (k == lat) begin
                done_seen = 1'b1;
                n_vec++;
                if (bus.core_rdata !== exp_rd) begin
                    $display("FAIL core_rdata: addr=%h we=%0d got %h want %h",
                             addr, we, bus.core_rdata, exp_rd);
                    n_err++;
                end
            end

            if (bus.mem_store_control) tb_mem[bus.mem_address] = bus.mem_wdata;

`ifdef DMEM_CACHE_SNOOP_INV_EN
            if (k == 1 && snp_fill) begin
                snoop_valid = 1'b1;
                snoop_addr  = addr;
            end else begin
                snoop_valid = 1'b0;
            end
`endif
            // Request is still held, but its fields must now be ignored.
            bus.core_we    = 1'($urandom_range(1, 0));
            bus.core_addr  = ADDR_W'($urandom_range(DEPTH - 1, 0));
            bus.core_wdata = $urandom;
        end

        if (we) begin
            ref_mem[addr] = wdata;
        end else begin
            line_addr[idx] = int'(addr);
            last_rdata     = exp_rd;
            if (snp_fill) line_addr[idx] = -1;
        end
`ifdef DMEM_CACHE_SNOOP_INV_EN
        snoop_valid = 1'b0;
`endif
        bus.core_req = 1'b0;
        after_done   = 1'b1;
    endtask

    task automatic test_reset();
        reset          = 1'b1;
        bus.core_req   = 1'b0;
        bus.core_we    = 1'b0;
        bus.core_addr  = '0;
        bus.core_wdata = '0;
`ifdef DMEM_CACHE_SNOOP_INV_EN
        snoop_valid = 1'b0;
        snoop_addr  = '0;
`endif
        repeat (3) @(negedge clk);
        n_vec++;
        if ({bus.core_done, bus.mem_load_control, bus.mem_store_control} !== 3'b000) begin
            $display("FAIL reset_ctrl: got done/ld/st=%b want 000",
                     {bus.core_done, bus.mem_load_control, bus.mem_store_control});
            n_err++;
        end
        n_vec++;
        if ({bus.mem_address, bus.mem_wdata, bus.core_rdata} !== '0) begin
            $display("FAIL reset_data: got addr=%h wdata=%h rdata=%h want 0",
                     bus.mem_address, bus.mem_wdata, bus.core_rdata);
            n_err++;
        end
        reset = 1'b0;
        model_clear();
        after_done = 1'b0;
    endtask

    task automatic test_directed();
        run_txn(1'b0, 4'h5, '0, 1, 1'b0);              // miss, fill 0xDEADBEEF
        run_txn(1'b0, 4'h5, '0, 1, 1'b0);              // hit
        run_txn(1'b1, 4'h5, 32'h1234_5678, 1, 1'b0);   // store hit
        run_txn(1'b0, 4'h5, '0, 1, 1'b0);              // hit returns new value
        run_txn(1'b1, 4'h9, 32'hCAFE_0009, 1, 1'b0);   // store miss, no allocate
        run_txn(1'b0, 4'h9, '0, 1, 1'b0);              // fill returns stored value
        run_txn(1'b0, 4'h1, '0, 1, 1'b0);              // same index, other tag
        run_txn(1'b0, 4'h5, '0, 1, 1'b0);              // evicts 0x1
        run_txn(1'b0, 4'h1, '0, 1, 1'b0);              // misses again
        n_vec++;
        if (tb_mem[5] !== 32'h1234_5678) begin
            $display("FAIL write_through: got mem[5]=%h want 12345678", tb_mem[5]);
            n_err++;
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 40; i++) begin
            run_txn(1'($urandom_range(1, 0)), ADDR_W'($urandom_range(DEPTH - 1, 0)),
                    $urandom, 0, 1'b0);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 250; i++) begin
            // Bias toward a few addresses so hits and conflict evictions are common.
            run_txn(($urandom_range(3, 0) == 0),
                    ADDR_W'($urandom_range(1, 0) ? $urandom_range(DEPTH - 1, 0)
                                                 : $urandom_range(7, 4)),
                    $urandom, int'($urandom_range(2, 0)), 1'b0);
        end
    endtask

    task automatic test_reset_mid();
        run_txn(1'b0, 4'h3, '0, 1, 1'b0);
        @(negedge clk);
        bus.core_req  = 1'b1;
        bus.core_we   = 1'b0;
        bus.core_addr = 4'h7;
        @(negedge clk);                                  // FILL cycle for 0x7
        n_vec++;
        if (bus.mem_load_control !== 1'b1) begin
            $display("FAIL mid_fill: got ld=%b want 1", bus.mem_load_control);
            n_err++;
        end
        reset        = 1'b1;
        bus.core_req = 1'b0;
        @(negedge clk);
        n_vec++;
        if ({bus.core_done, bus.mem_load_control, bus.mem_store_control, bus.mem_address} !== '0) begin
            $display("FAIL mid_reset_ctrl: got done=%b ld=%b st=%b addr=%h want 0",
                     bus.core_done, bus.mem_load_control, bus.mem_store_control, bus.mem_address);
            n_err++;
        end
        n_vec++;
        if (bus.core_rdata !== '0) begin
            $display("FAIL mid_reset_rdata: got %h want 0", bus.core_rdata);
            n_err++;
        end
        reset = 1'b0;
        model_clear();
        after_done = 1'b0;
        @(negedge clk);
        n_vec++;
        if (bus.core_done !== 1'b0) begin
            $display("FAIL mid_reset_done: got %b want 0", bus.core_done);
            n_err++;
        end
        run_txn(1'b0, 4'h3, '0, 1, 1'b0);                // valid bits cleared -> miss
    endtask

`ifdef DMEM_CACHE_SNOOP_INV_EN
    task automatic snoop_pulse(input logic [ADDR_W-1:0] a);
        snoop_valid = 1'b1;
        snoop_addr  = a;
        @(negedge clk);
        snoop_valid = 1'b0;
        after_done  = 1'b0;
        snoop_model(a);
    endtask

    task automatic test_snoop();
        run_txn(1'b0, 4'h5, '0, 1, 1'b0);
        snoop_pulse(4'hD);                               // same index, other tag
        run_txn(1'b0, 4'h5, '0, 1, 1'b0);                // still a hit
        snoop_pulse(4'h5);
        run_txn(1'b0, 4'h5, '0, 1, 1'b0);                // miss after invalidate
        run_txn(1'b0, 4'h9, '0, 1, 1'b0);                // evict 0x5
        run_txn(1'b0, 4'h5, '0, 1, 1'b1);                // snoop coincident with fill
        run_txn(1'b0, 4'h5, '0, 1, 1'b0);                // line left invalid -> miss
    endtask
`endif

    initial begin
        n_vec = 0;
        n_err = 0;
        for (int i = 0; i < DEPTH; i++) begin
            tb_mem[i]  = $urandom;
            ref_mem[i] = tb_mem[i];
        end
        tb_mem[5]  = 32'hDEAD_BEEF;
        ref_mem[5] = 32'hDEAD_BEEF;

        test_reset();
        test_directed();
        test_back_to_back();
        test_random();
        test_reset_mid();
`ifdef DMEM_CACHE_SNOOP_INV_EN
        test_snoop();
`endif
        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/dmem_cache_ctrl.md
Name: dmem_cache_ctrl

Overview:
- Initiator side of the data memory load/store interface: a small direct-mapped, write-through, no-write-allocate L1 data cache controller per core.
- Accepts single-word core requests over a req/done handshake.
- Serves read hits locally; drives the memory port (address, wdata, load_control, store_control; asynchronous read data) for misses and all writes.
- Sits between each core and the shared data memory in the two-core system.

Parameters:
- ADDR_W, 4, word address width; must match the data memory address width.
- DATA_W, 32, data word width.
- INDEX_W, 2, cache index width; 2^INDEX_W lines, one word per line; tag width = ADDR_W-INDEX_W.

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  synchronous, active-high reset
- core_req  in  1  request valid; held until core_done
- core_we  in  1  1=store, 0=load; sampled with core_req
- core_addr  in  ADDR_W  word address
- core_wdata  in  DATA_W  store data
- core_done  out  1  one-cycle completion pulse
- core_rdata  out  DATA_W  load result; valid with core_done, held until next load completes
- mem_address  out  ADDR_W  memory word address
- mem_wdata  out  DATA_W  memory store data
- mem_load_control  out  1  memory read enable; read data returns the same cycle
- mem_store_control  out  1  memory write enable; write commits at the clock edge
- mem_rdata  in  DATA_W  memory read data (asynchronous)

Behaviour:
- Reset: state=IDLE; all valid bits=0; core_done=0; core_rdata=0; mem_* outputs=0. Reset mid-transaction aborts it: no core_done, memory controls low from the cycle after the edge.
- Storage: valid[2^INDEX_W], tag[2^INDEX_W], data[2^INDEX_W]. Index = addr[INDEX_W-1:0]; tag = addr[ADDR_W-1:INDEX_W].
- IDLE: at an edge with core_req=1, latch addr, we and wdata.
  - Load hit: core_rdata <= line data; go to RESP.
  - Load miss: go to FILL.
  - Store: go to WRITE.
- FILL (exactly 1 cycle):
  - Drive mem_load_control=1 and mem_address=addr_q.
  - At the edge: data[idx] <= mem_rdata, tag[idx] <= tag_q, valid[idx] <= 1, core_rdata <= mem_rdata; go to RESP.
- WRITE (exactly 1 cycle):
  - Drive mem_store_control=1, mem_address=addr_q and mem_wdata=wdata_q.
  - On a hit, data[idx] <= wdata_q; on a miss the cache is unchanged (no allocate). Go to RESP.
- RESP: core_done=1 for one cycle; go to IDLE.
  - The core must drop core_req during the RESP cycle unless it issues a new request.
  - A high core_req seen in IDLE always starts a new transaction; back-to-back requests are legal.
- Latency, counted from the edge at which the request is sampled (edge N): read hit, core_done in cycle N+1; read miss and all stores, core_done in cycle N+2.
- Outside FILL/WRITE: mem_load_control=0, mem_store_control=0, mem_address=0, mem_wdata=0. Never more than one of load_control/store_control high.
- core_we and core_addr changes while busy are ignored; only the latched copy is used.

Optional Feature:
- Macro: DMEM_CACHE_SNOOP_INV_EN.
- Defined: adds ports snoop_valid (in, 1) and snoop_addr (in, ADDR_W), driven from the other core's store_control and address.
  - At an edge with snoop_valid=1 and a valid line whose index and tag match snoop_addr, that line's valid bit is cleared.
  - If the snoop hits the same line as a FILL or WRITE-hit update in the same cycle, the snoop wins: the line ends invalid. core_rdata from the FILL is still returned.
  - Snoop handling does not stall the state machine.
- Undefined: the snoop ports do not exist; there is no invalidation and no coherence between cores.

Test Plan:
- Reset, then load addr 0x5 with memory[5]=0xDEADBEEF -> FILL with mem_load_control=1 and mem_address=5 for 1 cycle; core_done at N+2 with core_rdata=0xDEADBEEF.
- Repeat load 0x5 -> no memory control asserted; core_done at N+1 with core_rdata=0xDEADBEEF.
- Store 0x12345678 to 0x5 (hit) -> mem_store_control=1 for 1 cycle with mem_wdata=0x12345678; a following load 0x5 hits and returns 0x12345678.
- Store to 0x9 (miss), then load 0x9 -> the store does not allocate; the load takes the FILL path and returns the stored value from memory.
- Load 0x1, then load 0x5 (same index, different tag) -> the second load misses and evicts; a reload of 0x1 misses again.
- With DMEM_CACHE_SNOOP_INV_EN: cache 0x5, pulse snoop_valid with snoop_addr=0x5 -> the next load 0x5 misses (FILL); a snoop coincident with a FILL of 0x5 leaves the line invalid.
